// File: rtl/fare_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fare_pkg
//  Description : Shared types and constants for the taxi fare meter:
//                meter state encoding, display constants and the
//                saturating fare-step helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fare_pkg;

    // Meter state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } meter_state_t;

    // Largest fare the six-digit display can show (9999.99 yuan)
    localparam logic [19:0] PRICE_MAX = 20'd999_999;

    // Decimal point after the second digit from the right: xxxx.xx
    localparam logic [5:0]  POINT_FMT = 6'b000_100;

    // Adds one fare step and clamps at PRICE_MAX. The sum is formed one bit
    // wider than the fare so a step near the top of the range cannot wrap
    // before the clamp sees it.
    function automatic logic [19:0] price_step(input logic [19:0] cur,
                                               input logic [19:0] step);
        logic [20:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, PRICE_MAX}) begin
            return PRICE_MAX;
        end
        return sum[19:0];
    endfunction

endpackage : fare_pkg
`default_nettype wire

// File: rtl/sig_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sig_filter
//  Description : Conditions one asynchronous input pin: two-flop
//                synchroniser, stability filter and registered one-cycle
//                rise/fall strobes of the filtered level.
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_filter #(
    parameter int   FILT_CYC = 4,     // cycles a level must be stable (>= 1)
    parameter logic INIT     = 1'b0   // idle level of the pin after reset
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    localparam int            CW       = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q,  filt_d;
    logic          dly_q;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    // Stability filter: count consecutive cycles in which the synchronised
    // value disagrees with the filtered level; accept it on the FILT_CYC-th.
    // Any return to agreement restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = filt_q & ~dly_q;
        fall_d = ~filt_q & dly_q;
    end

    // Synchroniser, filter state and edge-strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
            filt_q  <= INIT;
            dly_q   <= INIT;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            dly_q   <= filt_q;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule : sig_filter
`default_nettype wire

// File: rtl/fare_meter.sv
`default_nettype none
// ============================================================================
//  Module      : fare_meter
//  Description : Taxi fare computation stage. Conditions the wheel-pulse and
//                status-key pins, runs the IDLE/RUN/STOP meter and
//                accumulates distance (100 m units) and fare (0.01 yuan)
//                for the seven-segment display driver downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fare_meter
    import fare_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int KEY_DEB_CYC    = 1_000_000,
    parameter int PULSE_FILT_CYC = 50,
    parameter int PULSE_PER_100M = 10,
    parameter int START_DIST     = 30,
    parameter int BASE_FARE      = 1000,
    parameter int STEP_FARE      = 20,
    parameter int BLINK_CYC      = 12_500_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pulse_port,
    input  logic        stat_port,
    output logic [19:0] price,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        stat_led
);

    // CLK_FREQ documents the clock the cycle counts were derived from
    localparam int             CLK_FREQ_HZ = CLK_FREQ;

    localparam int             PCW         = (PULSE_PER_100M > 1) ? $clog2(PULSE_PER_100M) : 1;
    localparam logic [PCW-1:0] PCNT_LAST   = PCW'(PULSE_PER_100M - 1);
    localparam int             BCW         = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_CYC - 1);
    localparam logic [15:0]    START_D16   = 16'(START_DIST);
    localparam logic [19:0]    BASE_PRICE  = 20'(BASE_FARE);
    localparam logic [19:0]    STEP_PRICE  = 20'(STEP_FARE);

    // Conditioned input strobes
    logic key_press;          // status key pressed (filtered 1 -> 0)
    logic wheel_evt;          // wheel pulse (filtered 0 -> 1)
    logic key_rise_unused;    // key release is not used by the meter
    logic wheel_fall_unused;  // trailing wheel edge is not used

    // Meter state
    meter_state_t   state_q,  state_d;
    logic [19:0]    price_q,  price_d;
    logic [15:0]    dist_q,   dist_d;
    logic [PCW-1:0] pcnt_q,   pcnt_d;
    logic [BCW-1:0] blink_q,  blink_d;
    logic           led_q,    led_d;
    logic           seg_en_q, seg_en_d;
    logic [15:0]    dist_inc;

    // Status key idles high (active-low button)
    sig_filter #(
        .FILT_CYC (KEY_DEB_CYC),
        .INIT     (1'b1)
    ) u_key_filt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (stat_port),
        .rise  (key_rise_unused),
        .fall  (key_press)
    );

    // Wheel pulse idles low
    sig_filter #(
        .FILT_CYC (PULSE_FILT_CYC),
        .INIT     (1'b0)
    ) u_pulse_filt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (pulse_port),
        .rise  (wheel_evt),
        .fall  (wheel_fall_unused)
    );

    // Distance plus one 100 m unit, held at the top of the 16-bit range
    assign dist_inc = (dist_q == 16'hFFFF) ? dist_q : dist_q + 16'd1;

    // Next-state logic for the meter; a key press always takes priority
    // over a wheel event arriving in the same cycle.
    always_comb begin
        state_d  = state_q;
        price_d  = price_q;
        dist_d   = dist_q;
        pcnt_d   = pcnt_q;
        blink_d  = blink_q;
        led_d    = led_q;
        seg_en_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                price_d = '0;
                dist_d  = '0;
                pcnt_d  = '0;
                blink_d = '0;
                led_d   = 1'b0;
                if (key_press) begin
                    state_d = ST_RUN;
                    price_d = BASE_PRICE;
                    led_d   = 1'b1;
                end
            end

            ST_RUN: begin
                led_d = 1'b1;
                if (key_press) begin
                    state_d = ST_STOP;
                    blink_d = '0;
                end else if (wheel_evt) begin
                    if (pcnt_q == PCNT_LAST) begin
                        pcnt_d = '0;
                        dist_d = dist_inc;
                        // Only distance beyond the base-fare allowance costs extra
                        if (dist_inc > START_D16) begin
                            price_d = price_step(price_q, STEP_PRICE);
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (key_press) begin
                    state_d = ST_IDLE;
                    price_d = '0;
                    dist_d  = '0;
                    pcnt_d  = '0;
                    blink_d = '0;
                    led_d   = 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    led_d   = ~led_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                price_d = '0;
                dist_d  = '0;
                pcnt_d  = '0;
                blink_d = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    // Meter registers, display enable included
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            price_q  <= '0;
            dist_q   <= '0;
            pcnt_q   <= '0;
            blink_q  <= '0;
            led_q    <= 1'b0;
            seg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            dist_q   <= dist_d;
            pcnt_q   <= pcnt_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign price    = price_q;
    assign point    = POINT_FMT;
    assign seg_en   = seg_en_q;
    assign sign     = 1'b0;
    assign stat_led = led_q;

endmodule : fare_meter
`default_nettype wire

// File: tb/tb_fare_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fare_meter
//  Description : Scoreboard bench for fare_meter. Two instances share the
//                pins: dut_a with the standard fares, dut_b with a base fare
//                just below the display limit to exercise the clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fare_meter;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b1;
    logic        pulse_port = 1'b0;
    logic        stat_port  = 1'b1;

    logic [19:0] price_a, price_b;
    logic [5:0]  point_a, point_b;
    logic        seg_en_a, seg_en_b;
    logic        sign_a, sign_b;
    logic        led_a, led_b;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [19:0] qa[$];
    logic [19:0] qb[$];
    logic [19:0] last_a = '0;
    logic [19:0] last_b = '0;

    always #5 sys_clk = ~sys_clk;

    fare_meter #(
        .KEY_DEB_CYC    (20),
        .PULSE_FILT_CYC (4),
        .BLINK_CYC      (8)
    ) dut_a (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pulse_port (pulse_port),
        .stat_port  (stat_port),
        .price      (price_a),
        .point      (point_a),
        .seg_en     (seg_en_a),
        .sign       (sign_a),
        .stat_led   (led_a)
    );

    fare_meter #(
        .KEY_DEB_CYC    (20),
        .PULSE_FILT_CYC (4),
        .BLINK_CYC      (8),
        .BASE_FARE      (999_990),
        .STEP_FARE      (20)
    ) dut_b (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pulse_port (pulse_port),
        .stat_port  (stat_port),
        .price      (price_b),
        .point      (point_b),
        .seg_en     (seg_en_b),
        .sign       (sign_b),
        .stat_led   (led_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every change of a displayed fare must match the next queued value
    always @(negedge sys_clk) begin
        if (price_a !== last_a) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL price_a: changed to %0d, no change expected", price_a);
            end else begin
                check("price_a", int'(price_a), int'(qa.pop_front()));
            end
            last_a = price_a;
        end
        if (price_b !== last_b) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL price_b: changed to %0d, no change expected", price_b);
            end else begin
                check("price_b", int'(price_b), int'(qb.pop_front()));
            end
            last_b = price_b;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        pulse_port = 1'b1;
        wait_clk(hi);
        pulse_port = 1'b0;
        wait_clk(lo);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(5, 5);
    endtask

    task automatic press();
        stat_port = 1'b0;
        wait_clk(30);
        stat_port = 1'b1;
        wait_clk(30);
    endtask

    task automatic led_hold(input string name, input logic v, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            wait_clk(1);
            if (led_a === v) cnt++;
        end
        check(name, cnt, n);
    endtask

    task automatic blink_check();
        int n;
        n = 0;
        while (led_a !== 1'b1 && n < 20) begin wait_clk(1); n++; end
        n = 0;
        while (led_a !== 1'b0 && n < 20) begin wait_clk(1); n++; end
        n = 0;
        while (led_a === 1'b0 && n < 20) begin wait_clk(1); n++; end
        check("blink low half", n, 8);
        n = 0;
        while (led_a === 1'b1 && n < 20) begin wait_clk(1); n++; end
        check("blink high half", n, 8);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset ----
        #1 sys_rst_n = 1'b0;
        wait_clk(3);
        check("reset price_a", int'(price_a), 0);
        check("reset price_b", int'(price_b), 0);
        check("reset stat_led", int'(led_a), 0);
        check("reset seg_en", int'(seg_en_a), 0);
        check("reset point", int'(point_a), 4);
        check("reset sign", int'(sign_a), 0);
        check("reset point_b/sign_b/led_b/seg_en_b", int'({point_b, sign_b, led_b, seg_en_b}), 32);
        sys_rst_n = 1'b1;
        check("seg_en at release", int'(seg_en_a), 0);
        wait_clk(1);
        check("seg_en after release", int'(seg_en_a), 1);
        wait_clk(5);

        // ---- bounced key press in IDLE -> RUN ----
        qa.push_back(20'd1000);
        qb.push_back(20'd999_990);
        repeat (2) begin
            stat_port = 1'b0; wait_clk(3);
            stat_port = 1'b1; wait_clk(3);
        end
        press();
        led_hold("run stat_led steady", 1'b1, 12);
        check("qa drained after start", qa.size(), 0);

        // ---- distance pricing ----
        pulses(300);
        check("price at 3 km", int'(price_a), 1000);
        qa.push_back(20'd1020);
        qb.push_back(20'd999_999);
        pulses(10);
        qa.push_back(20'd1040);
        pulses(10);
        check("qa drained after steps", qa.size(), 0);
        check("qb drained after clamp", qb.size(), 0);

        // ---- glitch rejection: 3 cycles rejected, 4 accepted ----
        pulse(3, 8);
        pulse(4, 8);
        pulses(8);
        check("price before 10th count", int'(price_a), 1040);
        qa.push_back(20'd1060);
        pulses(1);
        check("qa drained after glitch test", qa.size(), 0);

        // ---- leave pulse counter one short, then coincident key + wheel ----
        pulses(9);
        stat_port = 1'b0;
        wait_clk(16);
        pulse_port = 1'b1;
        wait_clk(6);
        pulse_port = 1'b0;
        wait_clk(8);
        stat_port = 1'b1;
        wait_clk(30);
        check("price frozen on stop", int'(price_a), 1060);

        // ---- STOP: blink, ignore wheel ----
        blink_check();
        pulses(50);
        check("price_a after STOP pulses", int'(price_a), 1060);
        check("price_b after STOP pulses", int'(price_b), 999_999);

        // ---- STOP -> IDLE ----
        qa.push_back(20'd0);
        qb.push_back(20'd0);
        press();
        led_hold("idle stat_led", 1'b0, 12);
        check("qa drained in idle", qa.size(), 0);
        pulses(5);

        // ---- reset mid-RUN ----
        qa.push_back(20'd1000);
        qb.push_back(20'd999_990);
        press();
        pulses(15);
        qa.push_back(20'd0);
        qb.push_back(20'd0);
        sys_rst_n = 1'b0;
        wait_clk(2);
        check("mid-run reset price", int'(price_a), 0);
        check("mid-run reset stat_led", int'(led_a), 0);
        check("mid-run reset seg_en", int'(seg_en_a), 0);
        sys_rst_n = 1'b1;
        wait_clk(1);
        check("seg_en after 2nd release", int'(seg_en_a), 1);

        // Back in IDLE: a press must start a fresh fare
        qa.push_back(20'd1000);
        qb.push_back(20'd999_990);
        press();
        check("run stat_led after restart", int'(led_a), 1);
        wait_clk(5);
        check("qa drained at end", qa.size(), 0);
        check("qb drained at end", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fare_meter
`default_nettype wire
